// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device transmitter with command FIFO.
//
// Buffers command bytes written with tbr and sends each one as a PS/2
// host request. A request holds ps2_clk low, drives the start bit and then
// sends the data bits LSB first, odd parity and stop. It then checks the
// device ACK. A watchdog covers every gap between device clock edges.
//
// Optional feature macro: PS2_TX_RETRY_EN. When it is defined, a NACK or a
// timeout restarts the same byte from INHIBIT up to MAX_RETRY times before
// err is reported. When it is undefined, the first failure reports err and
// the byte is discarded.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   tx_en     allows a new frame to start; a frame in progress always completes
//   ps2_data  open-drain PS/2 data (driven 0 or Z)
//   ps2_clk   open-drain PS/2 clock (driven 0 or Z)
//   tbr       1-cycle write strobe that pushes data into the FIFO
//   data      byte to transmit
//   sent      1-cycle pulse when a frame has been ACKed
//   err       1-cycle pulse when a frame failed or a write was dropped
//   err_code  valid with err: 01 timeout, 10 NACK, 11 FIFO overflow
//   full      FIFO full
//   busy      state machine is not idle
module ps2_host_tx #(
    parameter int CLK_HZ     = 25_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15000,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_RETRY  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    inout  wire        ps2_data,
    inout  wire        ps2_clk,
    input  logic       tbr,
    input  logic [7:0] data,
    output logic       sent,
    output logic       err,
    output logic [1:0] err_code,
    output logic       full,
    output logic       busy
);

    localparam int INH_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int TO_CYC  = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int T_MAX   = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
    localparam int TW      = $clog2(T_MAX + 1);
    localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int RW      = $clog2(MAX_RETRY + 2);

`ifdef PS2_TX_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_WAIT_IDLE,
        S_FAIL
    } state_t;

    // ---------------------------------------------------------------
    // Pin drivers and input synchronisers
    // ---------------------------------------------------------------
    logic clk_oe_reg;
    logic data_oe_reg;

    assign ps2_clk  = clk_oe_reg  ? 1'b0 : 1'bz;
    assign ps2_data = data_oe_reg ? 1'b0 : 1'bz;

    logic clk_s1_reg, clk_sync_reg, clk_prev_reg;
    logic data_s1_reg, data_sync_reg;
    logic fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_reg    <= 1'b1;
            clk_sync_reg  <= 1'b1;
            clk_prev_reg  <= 1'b1;
            data_s1_reg   <= 1'b1;
            data_sync_reg <= 1'b1;
        end else begin
            clk_s1_reg    <= ps2_clk;
            clk_sync_reg  <= clk_s1_reg;
            clk_prev_reg  <= clk_sync_reg;
            data_s1_reg   <= ps2_data;
            data_sync_reg <= data_s1_reg;
        end
    end

    assign fall = clk_prev_reg & ~clk_sync_reg;

    // ---------------------------------------------------------------
    // Command FIFO
    // ---------------------------------------------------------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          empty, push, pop, ovf;

    state_t state_reg;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign pop   = (state_reg == S_IDLE) && tx_en && !empty;
    // A pop in the same cycle frees a slot, so the write is accepted.
    assign push  = tbr && (!full || pop);
    assign ovf   = tbr && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Frame state machine
    // ---------------------------------------------------------------
    logic [7:0]    shreg_reg;
    logic [3:0]    bitcnt_reg;
    logic [TW-1:0] timer_reg;
    logic [RW-1:0] retry_cnt_reg;
    logic [1:0]    fail_code_reg;
    logic          sent_reg, err_reg, ovf_pend_reg;
    logic [1:0]    err_code_reg;
    logic          retry_now, fail_pulse, sent_now, ovf_any;

    assign retry_now  = RETRY_EN && (retry_cnt_reg < RW'(MAX_RETRY));
    assign fail_pulse = (state_reg == S_FAIL) && !retry_now;
    assign sent_now   = (state_reg == S_WAIT_IDLE) && clk_sync_reg && data_sync_reg;
    assign ovf_any    = ovf | ovf_pend_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            clk_oe_reg    <= 1'b0;
            data_oe_reg   <= 1'b0;
            shreg_reg     <= '0;
            bitcnt_reg    <= '0;
            timer_reg     <= '0;
            retry_cnt_reg <= '0;
            fail_code_reg <= 2'b00;
            sent_reg      <= 1'b0;
            err_reg       <= 1'b0;
            err_code_reg  <= 2'b00;
            ovf_pend_reg  <= 1'b0;
        end else begin
            sent_reg <= sent_now;
            err_reg  <= 1'b0;

            // A frame failure takes the err slot; an overflow that collides
            // with sent or a frame failure is reported on the next cycle so
            // that sent and err never overlap.
            if (fail_pulse) begin
                err_reg      <= 1'b1;
                err_code_reg <= fail_code_reg;
            end else if (ovf_any && !sent_now) begin
                err_reg      <= 1'b1;
                err_code_reg <= 2'b11;
            end
            ovf_pend_reg <= ovf_any && (fail_pulse || sent_now);

            case (state_reg)
                S_IDLE: begin
                    bitcnt_reg <= '0;
                    if (pop) begin
                        shreg_reg     <= mem[rd_ptr_reg];
                        clk_oe_reg    <= 1'b1;
                        timer_reg     <= '0;
                        retry_cnt_reg <= '0;
                        state_reg     <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (timer_reg == TW'(INH_CYC - 1)) begin
                        clk_oe_reg  <= 1'b0;
                        data_oe_reg <= 1'b1;   // start bit
                        timer_reg   <= '0;
                        bitcnt_reg  <= '0;
                        state_reg   <= S_REQ;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                S_REQ: begin
                    if (fall) begin
                        timer_reg  <= '0;
                        bitcnt_reg <= bitcnt_reg + 1'b1;
                        // bitcnt_reg holds the number of falls seen so far,
                        // so it is also the index of the bit for this fall.
                        if (bitcnt_reg < 4'd8) begin
                            data_oe_reg <= ~shreg_reg[bitcnt_reg[2:0]];
                        end else if (bitcnt_reg == 4'd8) begin
                            // Parity bit is ~^data; pull low when it is 0.
                            data_oe_reg <= ^shreg_reg;
                        end else if (bitcnt_reg == 4'd9) begin
                            data_oe_reg <= 1'b0;   // stop bit
                        end else begin
                            if (!data_sync_reg) begin
                                state_reg <= S_WAIT_IDLE;
                            end else begin
                                fail_code_reg <= 2'b10;
                                state_reg     <= S_FAIL;
                            end
                        end
                    end else if (timer_reg == TW'(TO_CYC - 1)) begin
                        data_oe_reg   <= 1'b0;
                        fail_code_reg <= 2'b01;
                        state_reg     <= S_FAIL;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                S_WAIT_IDLE: begin
                    if (sent_now) begin
                        state_reg <= S_IDLE;
                    end else if (fall) begin
                        timer_reg <= '0;
                    end else if (timer_reg == TW'(TO_CYC - 1)) begin
                        fail_code_reg <= 2'b01;
                        state_reg     <= S_FAIL;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                S_FAIL: begin
                    data_oe_reg <= 1'b0;
                    timer_reg   <= '0;
                    if (retry_now) begin
                        // Same byte is still in shreg_reg; restart the request.
                        retry_cnt_reg <= retry_cnt_reg + 1'b1;
                        clk_oe_reg    <= 1'b1;
                        state_reg     <= S_INHIBIT;
                    end else begin
                        clk_oe_reg <= 1'b0;
                        state_reg  <= S_IDLE;
                    end
                end

                default: begin
                    clk_oe_reg  <= 1'b0;
                    data_oe_reg <= 1'b0;
                    state_reg   <= S_IDLE;
                end
            endcase
        end
    end

    assign sent     = sent_reg;
    assign err      = err_reg;
    assign err_code = err_code_reg;
    assign busy     = (state_reg != S_IDLE);

endmodule
